scalar_alu_pipe: RTL and testbench
==================================

SCALAR_ALU_PIPE -- requirements
Module: scalar_alu_pipe

Interface
REQ-001 Parameter DATA_W, default 64; maximum operand/result width; SHALL be 32 or 64.
REQ-002 Parameter MUL_CYCLES, default 4; iterations of the multiplier; range 1..8.
REQ-003 clock  input  1  sole clock; all state on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 in_op  input  5  internal opcode (salu_op_e).
REQ-008 in_wide  input  1  1 = 64-bit operation (ignored, treated 0, when DATA_W=32).
REQ-009 in_src0, in_src1  input  DATA_W  operand values.
REQ-010 in_simm  input  16  SOPK immediate.
REQ-011 in_sdst  input  7  destination register index, carried to output.
REQ-012 in_scc  input  1  current SCC value.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_data  output  DATA_W  result value.
REQ-016 out_sdst  output  7  destination index.
REQ-017 out_wr  output  1  write out_data to out_sdst (0 for compares).
REQ-018 out_scc  output  1  new SCC value.

Function
REQ-019 Transfer SHALL occur on in_valid&in_ready, and on out_valid&out_ready.
REQ-020 Pipeline SHALL be two stages (EX, WB); single-cycle ops appear on out_valid the cycle after acceptance (latency 1).
REQ-021 in_ready SHALL equal (~wb_valid | out_ready) & (fsm==IDLE).
REQ-022 Ops: MOV, NOT, AND, OR, XOR (all widths); ADD, SUB, LSHL, LSHR, ASHR, MIN_I, MIN_U, MAX_I, MAX_U (32 or 64 per in_wide); CMP_EQ, CMP_LG, CMP_LT_I, CMP_LT_U; MOVK, ADDK; MUL_I32.
REQ-023 32-bit ops SHALL zero-extend result bits DATA_W-1:32.
REQ-024 SCC: ADD = unsigned carry-out; SUB = unsigned borrow; AND/OR/XOR/NOT/shifts = result!=0; MIN/MAX = src0 selected; CMP = comparison result; MOV/MOVK/MUL = in_scc unchanged; ADDK = signed overflow.
REQ-025 Shift amount SHALL be src1[4:0] (32-bit) or src1[5:0] (64-bit).
REQ-026 MOVK result SHALL be sign-extended in_simm; ADDK result = src0[31:0] + sext(in_simm).
REQ-027 Compares SHALL drive out_wr=0, out_data=0.
REQ-028 MUL_I32 FSM states IDLE->MUL->IDLE; on acceptance enter MUL, iterate MUL_CYCLES cycles, then load WB; low 32 bits of signed product.
REQ-029 While in MUL, in_ready SHALL be 0; WB SHALL hold any earlier result until out_ready.
REQ-030 Back-pressure: with out_valid&~out_ready, WB SHALL hold all outputs stable.
REQ-031 Unknown opcode SHALL complete as MOV with out_wr=0, SCC unchanged.

Reset
REQ-032 On reset_n=0, immediately: out_valid=0, out_data=0, out_sdst=0, out_wr=0, out_scc=0, FSM=IDLE, multiplier state cleared.
REQ-033 Reset asserted mid-multiply SHALL abandon the operation; no result SHALL appear.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 Package salu_pkg SHALL hold salu_op_e, fsm state type, and width constants.
REQ-036 Multiplier SHALL be sub-module salu_mul_iter (start/done handshake, MUL_CYCLES parameter).

Verification
REQ-037 ADD 32-bit: src0=0xFFFFFFFF, src1=1 -> out_data=0, out_scc=1, out_valid next cycle.
REQ-038 CMP_LT_I: src0=0xFFFFFFFF (-1), src1=0 -> out_scc=1, out_wr=0; CMP_LT_U with the same operands -> out_scc=0.
REQ-039 MUL_I32: src0=-3, src1=7, MUL_CYCLES=4 -> in_ready low 4 cycles, out_data=0xFFFFFFEB.
REQ-040 Back-pressure: out_ready=0 for 3 cycles with 2 ops offered -> second op not accepted, first held stable, then both delivered in order.
REQ-041 Reset mid-MUL: reset_n pulses low in the 2nd MUL cycle -> out_valid=0, in_ready=1 after release.
REQ-042 64-bit LSHL: src0=1, src1=63, in_wide=1 -> out_data=0x8000000000000000, out_scc=1; ADDK src0=5, simm=0xFFFF -> out_data=4.

Source files
------------

// File: rtl/salu_pkg.sv
// salu_pkg: opcodes, FSM state type and width constants shared by the scalar ALU
//   OP_W/SDST_W/SIMM_W  opcode, destination index and SOPK immediate widths
//   W32/W64             operand widths for narrow and wide operations
//   salu_op_e           internal opcode encoding; values 21..31 are unused
//   salu_fsm_e          multiply sequencing state
package salu_pkg;

   localparam int OP_W   = 5;
   localparam int SDST_W = 7;
   localparam int SIMM_W = 16;
   localparam int W32    = 32;
   localparam int W64    = 64;

   typedef enum logic [OP_W-1:0] {
      OP_MOV      = 5'd0,
      OP_NOT      = 5'd1,
      OP_AND      = 5'd2,
      OP_OR       = 5'd3,
      OP_XOR      = 5'd4,
      OP_ADD      = 5'd5,
      OP_SUB      = 5'd6,
      OP_LSHL     = 5'd7,
      OP_LSHR     = 5'd8,
      OP_ASHR     = 5'd9,
      OP_MIN_I    = 5'd10,
      OP_MIN_U    = 5'd11,
      OP_MAX_I    = 5'd12,
      OP_MAX_U    = 5'd13,
      OP_CMP_EQ   = 5'd14,
      OP_CMP_LG   = 5'd15,
      OP_CMP_LT_I = 5'd16,
      OP_CMP_LT_U = 5'd17,
      OP_MOVK     = 5'd18,
      OP_ADDK     = 5'd19,
      OP_MUL_I32  = 5'd20
   } salu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } salu_fsm_e;

endpackage

// File: rtl/salu_mul_iter.sv
// salu_mul_iter: iterative 32x32 multiplier returning the low 32 product bits
//   clock, reset_n   clock, async active-low reset
//   start            load operands and begin MUL_CYCLES iterations
//   ack              result taken; go idle
//   a, b             operands (low 32 bits of signed product == unsigned product)
//   done             product valid (combinationally during the last iteration,
//                    then held in the accumulator until ack)
//   product          low 32 bits of a*b
module salu_mul_iter #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        ack,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] product
);

   // Each iteration consumes CH multiplier bits; CH*MUL_CYCLES covers all 32.
   localparam int CH = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
   localparam int CW = $clog2(MUL_CYCLES + 1);

   logic          run;
   logic [CW-1:0] cnt;
   logic [31:0]   mcand, mplier, acc, term;

   assign term    = mcand * 32'(mplier[CH-1:0]);
   assign done    = run && (cnt <= CW'(1));
   assign product = (cnt == '0) ? acc : acc + term;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         run    <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         run    <= 1'b1;
         cnt    <= CW'(MUL_CYCLES);
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else begin
         if (ack)
            run <= 1'b0;
         if (run && cnt != '0) begin
            acc    <= acc + term;
            mcand  <= mcand << CH;
            mplier <= mplier >> CH;
            cnt    <= cnt - CW'(1);
         end
      end

endmodule

// File: rtl/scalar_alu_pipe.sv
// scalar_alu_pipe: two-stage (EX, WB) scalar ALU with an iterative 32-bit multiply
//   clock, reset_n        clock, async active-low reset
//   in_valid/in_ready     operation handshake
//   in_op, in_wide        opcode, 64-bit select (forced 0 when DATA_W=32)
//   in_src0/1, in_simm    operands and SOPK immediate
//   in_sdst, in_scc       destination index and current SCC
//   out_valid/out_ready   result handshake
//   out_data, out_sdst    result value and destination index
//   out_wr, out_scc       register write enable and new SCC
module scalar_alu_pipe
   import salu_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic              in_wide,
   input  logic [DATA_W-1:0] in_src0,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [SIMM_W-1:0] in_simm,
   input  logic [SDST_W-1:0] in_sdst,
   input  logic              in_scc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SDST_W-1:0] out_sdst,
   output logic              out_wr,
   output logic              out_scc
);

   salu_fsm_e         fsm, fsm_nx;
   logic              wide, wb_free, is_mul, alu_ld, mul_start, mul_ld, mul_done;
   logic              alu_wr, alu_scc, scc_f, nz;
   logic              carry, borrow, eq, lt_i, gt_i, gt_u;
   logic [W64-1:0]    a, b, raw, res, ashr64;
   logic [W32-1:0]    ashr32, simx, addk, mul_prod;
   logic [W32:0]      add32;
   logic [W64:0]      add64;
   logic [5:0]        sh;
   logic [SDST_W-1:0] mul_sdst;
   logic              mul_scc;

   // Everything is computed at 64 bits; narrow ops use the low half and are
   // zero-extended afterwards.
   assign a      = 64'(in_src0);
   assign b      = 64'(in_src1);
   assign wide   = (DATA_W == W64) && in_wide;
   assign sh     = wide ? b[5:0] : {1'b0, b[4:0]};
   assign add32  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
   assign add64  = {1'b0, a} + {1'b0, b};
   assign carry  = wide ? add64[W64] : add32[W32];
   assign borrow = wide ? a < b : a[31:0] < b[31:0];
   assign eq     = wide ? a == b : a[31:0] == b[31:0];
   assign gt_u   = wide ? a > b : a[31:0] > b[31:0];
   assign lt_i   = wide ? $signed(a) < $signed(b) : $signed(a[31:0]) < $signed(b[31:0]);
   assign gt_i   = wide ? $signed(a) > $signed(b) : $signed(a[31:0]) > $signed(b[31:0]);
   // Kept as separate nets so the arithmetic shifts stay signed.
   assign ashr64 = $signed(a) >>> sh;
   assign ashr32 = $signed(a[31:0]) >>> sh[4:0];
   assign simx   = {{16{in_simm[15]}}, in_simm};
   assign addk   = a[31:0] + simx;

   always_comb begin
      raw     = a;
      alu_scc = in_scc;
      alu_wr  = 1'b1;
      nz      = 1'b0;
      case (salu_op_e'(in_op))
         OP_MOV:      raw = a;
         OP_NOT:      begin raw = ~a;     nz = 1'b1; end
         OP_AND:      begin raw = a & b;  nz = 1'b1; end
         OP_OR:       begin raw = a | b;  nz = 1'b1; end
         OP_XOR:      begin raw = a ^ b;  nz = 1'b1; end
         OP_ADD:      begin raw = wide ? add64[63:0] : {32'b0, add32[31:0]}; alu_scc = carry; end
         OP_SUB:      begin raw = a - b;  alu_scc = borrow; end
         OP_LSHL:     begin raw = a << sh; nz = 1'b1; end
         OP_LSHR:     begin raw = wide ? a >> sh : {32'b0, a[31:0] >> sh[4:0]}; nz = 1'b1; end
         OP_ASHR:     begin raw = wide ? ashr64 : {32'b0, ashr32}; nz = 1'b1; end
         OP_MIN_I:    begin raw = lt_i ? a : b;   alu_scc = lt_i; end
         OP_MIN_U:    begin raw = borrow ? a : b; alu_scc = borrow; end
         OP_MAX_I:    begin raw = gt_i ? a : b;   alu_scc = gt_i; end
         OP_MAX_U:    begin raw = gt_u ? a : b;   alu_scc = gt_u; end
         OP_CMP_EQ:   begin raw = '0; alu_wr = 1'b0; alu_scc = eq; end
         OP_CMP_LG:   begin raw = '0; alu_wr = 1'b0; alu_scc = ~eq; end
         OP_CMP_LT_I: begin raw = '0; alu_wr = 1'b0; alu_scc = lt_i; end
         OP_CMP_LT_U: begin raw = '0; alu_wr = 1'b0; alu_scc = borrow; end
         OP_MOVK:     raw = {32'b0, simx};
         // Signed overflow: like-signed operands giving a differently-signed sum.
         OP_ADDK:     begin raw = {32'b0, addk}; alu_scc = (a[31] == simx[31]) && (addk[31] != a[31]); end
         // Unknown opcodes behave as MOV without a register write.
         default:     alu_wr = 1'b0;
      endcase
   end

   assign res     = wide ? raw : {32'b0, raw[31:0]};
   assign scc_f   = nz ? (res != '0) : alu_scc;
   assign is_mul  = in_op == OP_MUL_I32;
   assign wb_free = ~out_valid | out_ready;
   assign alu_ld  = in_valid & in_ready & ~is_mul;

   always_comb begin
      fsm_nx    = fsm;
      mul_start = 1'b0;
      mul_ld    = 1'b0;
      in_ready  = wb_free && (fsm == S_IDLE);
      case (fsm)
         S_IDLE:  if (in_valid && in_ready && is_mul) begin fsm_nx = S_MUL; mul_start = 1'b1; end
         S_MUL:   if (mul_done && wb_free) begin fsm_nx = S_IDLE; mul_ld = 1'b1; end
         default: fsm_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         fsm      <= S_IDLE;
         mul_sdst <= '0;
         mul_scc  <= 1'b0;
      end else begin
         fsm <= fsm_nx;
         if (mul_start) begin
            mul_sdst <= in_sdst;
            mul_scc  <= in_scc;
         end
      end

   salu_mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (mul_start),
      .ack     (mul_ld),
      .a       (a[31:0]),
      .b       (b[31:0]),
      .done    (mul_done),
      .product (mul_prod)
   );

   // WB stage: a load only happens when the stage is empty or draining, so an
   // unaccepted result is never overwritten.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sdst  <= '0;
         out_wr    <= 1'b0;
         out_scc   <= 1'b0;
      end else if (alu_ld) begin
         out_valid <= 1'b1;
         out_data  <= res[DATA_W-1:0];
         out_sdst  <= in_sdst;
         out_wr    <= alu_wr;
         out_scc   <= scc_f;
      end else if (mul_ld) begin
         out_valid <= 1'b1;
         out_data  <= DATA_W'(mul_prod);
         out_sdst  <= mul_sdst;
         out_wr    <= 1'b1;
         out_scc   <= mul_scc;
      end else if (out_ready)
         out_valid <= 1'b0;

endmodule

// File: tb/tb_scalar_alu_pipe.sv
// tb_scalar_alu_pipe: vector table, corner sequences and randomized scoreboard for scalar_alu_pipe
module tb_scalar_alu_pipe;
   import salu_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, in_wide, in_scc;
   logic [4:0]  in_op;
   logic [63:0] in_src0, in_src1;
   logic [15:0] in_simm;
   logic [6:0]  in_sdst;
   logic        out_valid, out_ready, out_wr, out_scc;
   logic [63:0] out_data;
   logic [6:0]  out_sdst;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [63:0] data;
      logic        wr;
      logic        scc;
      logic [6:0]  sdst;
   } exp_t;

   typedef struct packed {
      logic [4:0]  op;
      logic        wide;
      logic [63:0] a;
      logic [63:0] b;
      logic [15:0] simm;
      logic        scc;
      logic [63:0] data;
      logic        wr;
      logic        oscc;
   } vec_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   scalar_alu_pipe #(.DATA_W(64), .MUL_CYCLES(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_wide   (in_wide),
      .in_src0   (in_src0),
      .in_src1   (in_src1),
      .in_simm   (in_simm),
      .in_sdst   (in_sdst),
      .in_scc    (in_scc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sdst  (out_sdst),
      .out_wr    (out_wr),
      .out_scc   (out_scc)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] simm, input logic [6:0] sdst, input logic scc);
      in_valid = 1'b1;
      in_op    = op;
      in_wide  = w;
      in_src0  = a;
      in_src1  = b;
      in_simm  = simm;
      in_sdst  = sdst;
      in_scc   = scc;
   endtask

   function automatic vec_t mkv(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                                input logic [15:0] simm, input logic scc,
                                input logic [63:0] data, input logic wr, input logic oscc);
      vec_t v;
      v.op = op; v.wide = w; v.a = a; v.b = b; v.simm = simm; v.scc = scc;
      v.data = data; v.wr = wr; v.oscc = oscc;
      return v;
   endfunction

   // Reference model: results derived directly from the operation definitions.
   function automatic exp_t model(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [15:0] simm, input logic [6:0] sdst, input logic scc);
      exp_t e;
      int n, amt;
      logic [63:0] m, am, bm;
      logic [127:0] s;
      longint sa, sb, k;
      n   = w ? 64 : 32;
      m   = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      am  = a & m;
      bm  = b & m;
      sa  = w ? longint'(a) : longint'($signed(a[31:0]));
      sb  = w ? longint'(b) : longint'($signed(b[31:0]));
      amt = w ? int'(b[5:0]) : int'(b[4:0]);
      e.data = 64'h0; e.wr = 1'b1; e.scc = scc; e.sdst = sdst;
      case (op)
         OP_MOV:      e.data = am;
         OP_NOT:      e.data = ~a & m;
         OP_AND:      e.data = am & bm;
         OP_OR:       e.data = am | bm;
         OP_XOR:      e.data = am ^ bm;
         OP_ADD:      begin s = {64'h0, am} + {64'h0, bm}; e.data = s[63:0] & m; e.scc = (s >> n) != 0; end
         OP_SUB:      begin e.data = (am - bm) & m; e.scc = am < bm; end
         OP_LSHL:     e.data = (a << amt) & m;
         OP_LSHR:     e.data = am >> amt;
         OP_ASHR:     e.data = 64'(sa >>> amt) & m;
         OP_MIN_I:    begin e.scc = sa < sb; e.data = e.scc ? am : bm; end
         OP_MIN_U:    begin e.scc = am < bm; e.data = e.scc ? am : bm; end
         OP_MAX_I:    begin e.scc = sa > sb; e.data = e.scc ? am : bm; end
         OP_MAX_U:    begin e.scc = am > bm; e.data = e.scc ? am : bm; end
         OP_CMP_EQ:   begin e.wr = 1'b0; e.scc = am == bm; end
         OP_CMP_LG:   begin e.wr = 1'b0; e.scc = am != bm; end
         OP_CMP_LT_I: begin e.wr = 1'b0; e.scc = sa < sb; end
         OP_CMP_LT_U: begin e.wr = 1'b0; e.scc = am < bm; end
         OP_MOVK:     e.data = 64'(longint'($signed(simm))) & 64'hFFFF_FFFF;
         OP_ADDK:     begin
            k = longint'($signed(a[31:0])) + longint'($signed(simm));
            e.data = 64'(k) & 64'hFFFF_FFFF;
            e.scc  = k != longint'($signed(k[31:0]));
         end
         OP_MUL_I32:  begin
            k = longint'($signed(a[31:0])) * longint'($signed(b[31:0]));
            e.data = 64'(k) & 64'hFFFF_FFFF;
         end
         default:     begin e.data = am; e.wr = 1'b0; end
      endcase
      if (op inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_LSHL, OP_LSHR, OP_ASHR}) e.scc = e.data != 0;
      return e;
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 6))
         0: return 64'h0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h0000_0000_8000_0000;
         3: return 64'h0000_0000_7FFF_FFFF;
         4: return 64'h8000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int lows, seen;
      exp_t e;
      logic [4:0] rop;
      vecs.push_back(mkv(OP_ADD,      0, 64'hFFFF_FFFF,          64'd1,                  16'h0,    0, 64'h0,                   1, 1));
      vecs.push_back(mkv(OP_CMP_LT_I, 0, 64'hFFFF_FFFF,          64'd0,                  16'h0,    0, 64'h0,                   0, 1));
      vecs.push_back(mkv(OP_CMP_LT_U, 0, 64'hFFFF_FFFF,          64'd0,                  16'h0,    1, 64'h0,                   0, 0));
      vecs.push_back(mkv(OP_LSHL,     1, 64'd1,                  64'd63,                 16'h0,    0, 64'h8000_0000_0000_0000, 1, 1));
      vecs.push_back(mkv(OP_ADDK,     0, 64'd5,                  64'd0,                  16'hFFFF, 1, 64'd4,                   1, 0));
      vecs.push_back(mkv(OP_SUB,      1, 64'd0,                  64'd1,                  16'h0,    0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1));
      vecs.push_back(mkv(OP_SUB,      0, 64'h1_0000_0005,        64'd3,                  16'h0,    1, 64'd2,                   1, 0));
      vecs.push_back(mkv(OP_ASHR,     0, 64'hFFFF_FFFF_8000_0000, 64'd4,                 16'h0,    0, 64'h0000_0000_F800_0000, 1, 1));
      vecs.push_back(mkv(OP_MIN_I,    0, 64'hFFFF_FFFE,          64'd3,                  16'h0,    0, 64'h0000_0000_FFFF_FFFE, 1, 1));
      vecs.push_back(mkv(OP_MAX_U,    1, 64'd5,                  64'h8000_0000_0000_0000, 16'h0,   1, 64'h8000_0000_0000_0000, 1, 0));
      vecs.push_back(mkv(OP_NOT,      0, 64'd0,                  64'd0,                  16'h0,    0, 64'h0000_0000_FFFF_FFFF, 1, 1));
      vecs.push_back(mkv(OP_XOR,      1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 16'h0,  1, 64'h0,                   1, 0));
      vecs.push_back(mkv(OP_MOVK,     1, 64'd0,                  64'd0,                  16'h8000, 1, 64'h0000_0000_FFFF_8000, 1, 1));
      vecs.push_back(mkv(OP_ADDK,     0, 64'h7FFF_FFFF,          64'd0,                  16'h0001, 0, 64'h0000_0000_8000_0000, 1, 1));
      vecs.push_back(mkv(OP_CMP_EQ,   1, 64'd7,                  64'd7,                  16'h0,    0, 64'h0,                   0, 1));
      vecs.push_back(mkv(5'd31,       1, 64'hDEAD,               64'd1,                  16'h0,    1, 64'hDEAD,                0, 1));
      vecs.push_back(mkv(OP_LSHR,     0, 64'hF_0000_0001,        64'h20,                 16'h0,    0, 64'd1,                   1, 1));

      // Reset state
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(OP_MOV, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_flags", {out_wr, out_scc, out_sdst}, 64'd0);
      reset_n = 1'b1;
      #1 check("rdy_after_rst", 64'(in_ready), 64'd1);
      @(negedge clock);

      // Vector table, one op at a time; result expected one cycle after acceptance
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].simm, 7'(i), vecs[i].scc);
         @(negedge clock);
         in_valid = 1'b0;
         #1;
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d_data", i), out_data, vecs[i].data);
         check($sformatf("vec%0d_flags", i), {out_wr, out_scc, out_sdst}, {vecs[i].wr, vecs[i].oscc, 7'(i)});
         @(negedge clock);
      end

      // MUL_I32: -3 * 7, in_ready low for MUL_CYCLES cycles
      drive(OP_MUL_I32, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 16'h0, 7'd9, 1'b1);
      @(negedge clock);
      in_valid = 1'b0;
      lows = 0;
      for (int c = 0; c < 20 && !out_valid; c++) begin
         if (!in_ready) lows++;
         @(negedge clock);
      end
      check("mul_result_valid", 64'(out_valid), 64'd1);
      check("mul_ready_low_cycles", 64'(lows), 64'd4);
      check("mul_data", out_data, 64'h0000_0000_FFFF_FFEB);
      check("mul_flags", {out_wr, out_scc, out_sdst}, {1'b1, 1'b1, 7'd9});
      check("mul_ready_after", 64'(in_ready), 64'd1);
      @(negedge clock);

      // Back-pressure: first result held, second op stalled, both delivered in order
      out_ready = 1'b0;
      drive(OP_ADD, 1, 64'd1, 64'd2, 16'h0, 7'd20, 1'b0);
      @(negedge clock);
      drive(OP_OR, 1, 64'hF0, 64'h0F, 16'h0, 7'd21, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("bp%0d_hold_data", k), out_data, 64'd3);
         check($sformatf("bp%0d_hold_ctl", k), {out_valid, out_wr, out_scc, out_sdst}, {1'b1, 1'b1, 1'b0, 7'd20});
         if (k < 2) @(negedge clock);
      end
      out_ready = 1'b1;
      #1 check("bp_release_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      check("bp_second_data", out_data, 64'hFF);
      check("bp_second_ctl", {out_valid, out_wr, out_scc, out_sdst}, {1'b1, 1'b1, 1'b1, 7'd21});
      @(negedge clock);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Asynchronous reset clears a held result without a clock edge
      out_ready = 1'b0;
      drive(OP_MOVK, 0, 64'd0, 64'd0, 16'h1234, 7'd3, 1'b1);
      @(negedge clock);
      in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_data", out_data, 64'd0);
      check("async_rst_flags", {out_wr, out_scc, out_sdst}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1; out_ready = 1'b1;
      @(negedge clock);

      // Reset in the 2nd MUL cycle abandons the multiply
      drive(OP_MUL_I32, 0, 64'd123, 64'd456, 16'h0, 7'd5, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1 check("midmul_rst_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("midmul_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (8) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      check("midmul_no_result", 64'(seen), 64'd0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         rop = 5'($urandom_range(0, 22));
         if (rop == 5'd21) rop = 5'd27;
         if (rop == 5'd22) rop = 5'd31;
         drive(rop, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 16'($urandom), 7'($urandom), 1'($urandom_range(0, 1)));
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL rnd_spurious: got out_valid=1 sdst=%h, expected no pending result", out_sdst);
            end else begin
               e = exp_q.pop_front();
               check("rnd_data", out_data, e.data);
               check("rnd_flags", {out_wr, out_scc, out_sdst}, {e.wr, e.scc, e.sdst});
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_op, in_wide, in_src0, in_src1, in_simm, in_sdst, in_scc));
         @(negedge clock);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
         #1;
         if (out_valid) begin
            e = exp_q.pop_front();
            check("drain_data", out_data, e.data);
            check("drain_flags", {out_wr, out_scc, out_sdst}, {e.wr, e.scc, e.sdst});
         end
         @(negedge clock);
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
